pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch. Computes PCSrc = Branch && Zero,
//  arbitrates next PC (jump > taken branch > sequential), drives a req/ready fetch handshake
//  to instruction memory, and squashes wrong-path fetches with a one-cycle Flush pulse.
//  Sits between control/ALU (Branch, Zero, Jump) and the instruction memory / IF stage.
// PARAMETERS
//  ADDR_W       32  PC / target width
//  RESET_PC     0   PC value loaded on reset
//  INSTR_BYTES  4   sequential increment; power of 2; target low log2(INSTR_BYTES) bits forced 0
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-high
//  ResolveValid  in   1       Branch/Zero/Jump/targets valid this cycle
//  Branch        in   1       instruction is conditional branch
//  Zero          in   1       ALU zero flag
//  BranchTarget  in   ADDR_W  taken-branch target
//  Jump          in   1       unconditional jump
//  JumpTarget    in   ADDR_W  jump target
//  Stall         in   1       hazard hold: no new fetch issued
//  IMemReady     in   1       memory accepts/completes current request
//  PCSrc         out  1       combinational: ResolveValid && Branch && Zero
//  IMemReq       out  1       fetch request, registered
//  PC            out  ADDR_W  fetch address, registered
//  FetchValid    out  1       registered; fetched word is right-path, one cycle after handshake
//  Flush         out  1       registered one-cycle pulse: downstream must discard in-flight instr
// BEHAVIOUR
//  - Reset (async): PC=RESET_PC, IMemReq=0, FetchValid=0, Flush=0, state=BOOT, pending cleared.
//    Reset mid-request abandons it; no handshake-completion effects.
//  - Handshake = IMemReq && IMemReady at a rising edge. Once raised, IMemReq and PC stay stable
//    until handshake; request never withdrawn (Stall/redirect do not cancel it).
//  - Redirect = ResolveValid && (Jump || Branch&&Zero); target = Jump ? JumpTarget : BranchTarget.
//  - States: BOOT -> REQ unconditionally next cycle. REQ: IMemReq=1.
//    On handshake: Stall=1 -> HOLD (IMemReq=0), else stay REQ, back-to-back (IMemReq stays 1).
//    HOLD: IMemReq=0, PC held; Stall=0 -> REQ next cycle.
//  - Next PC at handshake: pending target if pending, else redirect target if redirect this
//    cycle, else PC+INSTR_BYTES (mod 2^ADDR_W, wraps to 0).
//  - FetchValid=1 in cycle after a handshake only if no pending redirect and no redirect in
//    the handshake cycle; otherwise FetchValid=0 and Flush=1 that cycle.
//  - Redirect in REQ without handshake: target stored in pending register; newer redirect
//    overwrites older. Applied and cleared at handshake.
//  - Redirect in HOLD/BOOT: PC<=target next cycle, Flush=1 next cycle, no pending.
//  - Stall and redirect same cycle: redirect applied, Stall still honoured.
//  - ResolveValid=0: Branch/Zero/Jump ignored, PCSrc=0.
// CONFIGURATION
//  PC_SEQ_STATS_EN defined: adds output TakenCount[15:0], reset 0, +1 per cycle with PCSrc=1
//    (Jump not counted), saturates at 16'hFFFF.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset released, IMemReady=1, no resolve -> PC 0,4,8,12 consecutive; FetchValid=1 from
//    cycle after first handshake; Flush=0.
//  2 Branch=1,Zero=1,ResolveValid=1,BranchTarget=0x40 in handshake cycle of PC=8 -> PCSrc=1 that
//    cycle; next cycle FetchValid=0, Flush=1, PC=0x40.
//  3 Branch=1,Zero=0,ResolveValid=1 -> PCSrc=0, PC advances 8->0xC, FetchValid=1.
//  4 IMemReady=0 for 3 cycles at PC=0x10, Jump=1,JumpTarget=0x103 in wait cycle 1 -> PC/IMemReq
//    stable 0x10; after ready: FetchValid=0, Flush=1, PC=0x100.
//  5 Stall=1 for 2 cycles after handshake at PC=4 -> IMemReq=0, PC=8 held; Stall=0 -> req PC=8.
//  6 reset asserted mid-wait, PC=0x20 -> PC=RESET_PC, IMemReq=0 immediately, no edge required;
//    with PC_SEQ_STATS_EN, 3 taken branches -> TakenCount=3, reset -> 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: next-PC arbitration, req/ready fetch handshake, wrong-path flush.
// Optional PC_SEQ_STATS_EN adds a saturating taken-branch counter output TakenCount.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ResolveValid,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    input  logic              IMemReady,
    output logic              PCSrc,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] PC,
    output logic              FetchValid,
`ifdef PC_SEQ_STATS_EN
    output logic              Flush,
    output logic [15:0]       TakenCount
`else
    output logic              Flush
`endif
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

    typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx, pend_tgt, pend_tgt_nx, target;
    logic              req_nx, fv_nx, fl_nx, pend, pend_nx;
    logic              redirect, handshake;

    assign PCSrc     = ResolveValid && Branch && Zero;
    assign redirect  = ResolveValid && (Jump || (Branch && Zero));
    assign target    = (Jump ? JumpTarget : BranchTarget) & ALIGN_MASK;
    assign handshake = IMemReq && IMemReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            PC         <= RESET_PC;
            IMemReq    <= 1'b0;
            FetchValid <= 1'b0;
            Flush      <= 1'b0;
            pend       <= 1'b0;
            pend_tgt   <= '0;
        end else begin
            state      <= state_nx;
            PC         <= pc_nx;
            IMemReq    <= req_nx;
            FetchValid <= fv_nx;
            Flush      <= fl_nx;
            pend       <= pend_nx;
            pend_tgt   <= pend_tgt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = PC;
        fv_nx       = 1'b0;
        fl_nx       = 1'b0;
        pend_nx     = pend;
        pend_tgt_nx = pend_tgt;
        case (state)
            BOOT: begin
                state_nx = REQ;
                if (redirect) begin
                    pc_nx = target;
                    fl_nx = 1'b1;
                end
            end
            REQ: begin
                if (handshake) begin
                    // A redirect parked during the wait beats one arriving now: it is older.
                    if (pend)          pc_nx = pend_tgt;
                    else if (redirect) pc_nx = target;
                    else               pc_nx = PC + STEP;
                    fv_nx    = !(pend || redirect);
                    fl_nx    = pend || redirect;
                    pend_nx  = 1'b0;
                    state_nx = Stall ? HOLD : REQ;
                end else if (redirect) begin
                    // PC must stay stable while the request is outstanding, so park the target.
                    pend_nx     = 1'b1;
                    pend_tgt_nx = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx = target;
                    fl_nx = 1'b1;
                end
                if (!Stall) state_nx = REQ;
            end
            default: state_nx = BOOT;
        endcase
        req_nx = (state_nx == REQ);
    end

`ifdef PC_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              TakenCount <= '0;
        else if (PCSrc && TakenCount != 16'hFFFF) TakenCount <= TakenCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle queues the expected post-edge outputs,
// a monitor pops and compares them one time unit after every rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ResolveValid = 1'b0, Branch = 1'b0, Zero = 1'b0, Jump = 1'b0;
    logic [31:0] BranchTarget = '0, JumpTarget = '0;
    logic        Stall = 1'b0, IMemReady = 1'b0;
    logic        PCSrc, IMemReq, FetchValid, Flush;
    logic [31:0] PC;
`ifdef PC_SEQ_STATS_EN
    logic [15:0] TakenCount;
`endif

    pc_sequencer dut (
        .clk(clk), .reset(reset), .ResolveValid(ResolveValid), .Branch(Branch), .Zero(Zero),
        .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall),
        .IMemReady(IMemReady), .PCSrc(PCSrc), .IMemReq(IMemReq), .PC(PC),
`ifdef PC_SEQ_STATS_EN
        .FetchValid(FetchValid), .Flush(Flush), .TakenCount(TakenCount)
`else
        .FetchValid(FetchValid), .Flush(Flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        req, fv, fl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".pc"},  PC,                 e.pc);
            chk({e.tag, ".req"}, {31'd0, IMemReq},    {31'd0, e.req});
            chk({e.tag, ".fv"},  {31'd0, FetchValid}, {31'd0, e.fv});
            chk({e.tag, ".fl"},  {31'd0, Flush},      {31'd0, e.fl});
        end
    end

    // Called at a falling edge: drive one cycle of inputs, check PCSrc, queue the post-edge outputs.
    task automatic cyc(input int n, input logic rv, br, z, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic st, rdy,
                       input logic epcsrc, input logic [31:0] epc, input logic ereq, efv, efl);
        exp_t e;
        ResolveValid = rv; Branch = br; Zero = z; BranchTarget = bt;
        Jump = j; JumpTarget = jt; Stall = st; IMemReady = rdy;
        #1;
        chk($sformatf("s%0d.pcsrc", n), {31'd0, PCSrc}, {31'd0, epcsrc});
        e.tag = $sformatf("s%0d", n);
        e.pc = epc; e.req = ereq; e.fv = efv; e.fl = efl;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #3;
        chk("rst.pc", PC, 32'h0);
        chk("rst.req", {31'd0, IMemReq}, 32'd0);
        chk("rst.fv", {31'd0, FetchValid}, 32'd0);
        chk("rst.fl", {31'd0, Flush}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        //   n  rv br z  bt          j  jt          st rdy src pc           req fv fl
        cyc( 1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h0,        1, 0, 0);
        cyc( 2, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h4,        1, 1, 0);
        cyc( 3, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h8,        1, 1, 0);
        cyc( 4, 1, 1, 0, 32'h40,     0, 32'h0,      0, 1,  0, 32'hC,        1, 1, 0);
        cyc( 5, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h10,       1, 1, 0);
        cyc( 6, 1, 0, 0, 32'h0,      1, 32'h103,    0, 0,  0, 32'h10,       1, 0, 0);
        cyc( 7, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0,  0, 32'h10,       1, 0, 0);
        cyc( 8, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0,  0, 32'h10,       1, 0, 0);
        cyc( 9, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h100,      1, 0, 1);
        cyc(10, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h104,      1, 1, 0);
        cyc(11, 1, 0, 0, 32'h0,      1, 32'h8,      0, 1,  0, 32'h8,        1, 0, 1);
        cyc(12, 1, 1, 1, 32'h40,     0, 32'h0,      0, 1,  1, 32'h40,       1, 0, 1);
        cyc(13, 1, 0, 0, 32'h0,      1, 32'h4,      0, 1,  0, 32'h4,        1, 0, 1);
        cyc(14, 0, 0, 0, 32'h0,      0, 32'h0,      1, 1,  0, 32'h8,        0, 1, 0);
        cyc(15, 0, 0, 0, 32'h0,      0, 32'h0,      1, 1,  0, 32'h8,        0, 0, 0);
        cyc(16, 1, 1, 1, 32'h80,     0, 32'h0,      1, 1,  1, 32'h80,       0, 0, 1);
        cyc(17, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h80,       1, 0, 0);
        cyc(18, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h84,       1, 1, 0);
        cyc(19, 1, 0, 0, 32'h0,      1, 32'hFFFFFFFC, 0, 1, 0, 32'hFFFFFFFC, 1, 0, 1);
        cyc(20, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h0,        1, 1, 0);
        cyc(21, 0, 1, 1, 32'h500,    1, 32'h500,    0, 1,  0, 32'h4,        1, 1, 0);
        cyc(22, 1, 1, 1, 32'h200,    0, 32'h0,      0, 0,  1, 32'h4,        1, 0, 0);
        cyc(23, 1, 0, 0, 32'h0,      1, 32'h300,    0, 0,  0, 32'h4,        1, 0, 0);
        cyc(24, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h300,      1, 0, 1);
        cyc(25, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0,  0, 32'h300,      1, 0, 0);
`ifdef PC_SEQ_STATS_EN
        chk("stats.count", {16'd0, TakenCount}, 32'd3);
`endif
        // Asynchronous reset in the middle of an outstanding request.
        #2 reset = 1'b1;
        #1;
        chk("midrst.pc", PC, 32'h0);
        chk("midrst.req", {31'd0, IMemReq}, 32'd0);
`ifdef PC_SEQ_STATS_EN
        chk("stats.rst", {16'd0, TakenCount}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        cyc(26, 1, 0, 0, 32'h0,      1, 32'h20,     0, 1,  0, 32'h20,       1, 0, 1);
        cyc(27, 0, 0, 0, 32'h0,      0, 32'h0,      0, 1,  0, 32'h24,       1, 1, 0);
        @(negedge clk);
        chk("drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
